midi_voice_decoder: RTL and testbench

//  Parses a MIDI byte stream into the per-channel note/velocity/pitch-bend/mod state.
//  The echo generator and the channel synths consume this state as note_on, note,
//  vel, pb and cc1 levels, plus a note_repeat pulse. Sits between the UART byte

---
 rtl/midi_voice_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_midi_voice_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/midi_voice_decoder.sv
// ---------------------------------------------------------------------------
// midi_voice_decoder
//
// Turns a received MIDI byte stream into the monophonic voice state of one
// MIDI channel: gate, note number, velocity, pitch bend and mod wheel. The
// echo generator and channel synths downstream read these levels directly.
// One instance per MIDI channel.
//
// The parser follows running status, drops realtime bytes wherever they
// appear, and swallows system-exclusive data. Completed channel-voice
// messages for other channels are parsed and then discarded.
//
// Parameters
//   CHANNEL      MIDI channel (0-15) this instance responds to
//   OMNI         1 = respond to all 16 channels (CHANNEL ignored)
//
// Ports
//   clk          in   1  system clock
//   reset_n      in   1  asynchronous active-low reset
//   byte_valid   in   1  one-cycle strobe qualifying byte_data
//   byte_data    in   8  received MIDI byte
//   note_on      out  1  gate, high while a note is held (last-note priority)
//   note_repeat  out  1  one-cycle pulse: note-on for the note already held
//   note         out  7  current / last note number
//   vel          out  7  velocity of current note, 0 after note-off
//   pb           out  9  pitch bend {msb[6:0], lsb[6:5]}, centre 9'h100
//   cc1          out  2  mod wheel, CC1 value[6:5]
//
// Build option
//   MIDI_DEC_ALL_NOTES_OFF_EN  when defined, CC120 / CC123 release the gate
//                              (note kept) and CC121 recentres pb and cc1.
//                              When undefined these CCs are ignored.
// ---------------------------------------------------------------------------
module midi_voice_decoder #(
  parameter int CHANNEL = 0,
  parameter int OMNI    = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       note_on,
  output logic       note_repeat,
  output logic [6:0] note,
  output logic [6:0] vel,
  output logic [8:0] pb,
  output logic [1:0] cc1
);

  // Parser states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA1 = 2'd1;
  localparam logic [1:0] DATA2 = 2'd2;
  localparam logic [1:0] SYSEX = 2'd3;

  localparam logic [3:0] CH       = CHANNEL[3:0];
  localparam logic [8:0] PB_CENTRE = 9'h100;

  // Program Change (Cn) and Channel Pressure (Dn) carry a single data byte.
  function automatic logic is_one_byte(input logic [7:0] status);
    return status[7:5] == 3'b110;
  endfunction

  // -------------------------------------------------------------------------
  // Parser state
  // -------------------------------------------------------------------------
  logic [1:0] state,    nxt_state;
  logic [7:0] rs,       nxt_rs;        // running status byte
  logic       rs_valid, nxt_rs_valid;
  logic [6:0] d1,       nxt_d1;        // first data byte of a 2-byte msg

  // Completed-message strobe and its data, valid in the cycle of the
  // completing byte; rs holds the status of the message being completed.
  logic       msg_done;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the decode leaves one unassigned and no latch is inferred.
    nxt_state    = state;
    nxt_rs       = rs;
    nxt_rs_valid = rs_valid;
    nxt_d1       = d1;
    msg_done     = 1'b0;
    msg_d1       = d1;
    msg_d2       = byte_data[6:0];

    if (byte_valid) begin
      if (byte_data >= 8'hF8) begin
        // Realtime: invisible to the parser in every state.
      end else if (byte_data == 8'hF0) begin
        nxt_state    = SYSEX;
        nxt_rs_valid = 1'b0;
      end else if (byte_data >= 8'hF1) begin
        // System common (F1-F7, F7 also ends SysEx): its data bytes fall into
        // IDLE with no running status and are dropped there.
        nxt_state    = IDLE;
        nxt_rs_valid = 1'b0;
      end else if (byte_data[7]) begin
        // Channel status: any partially received message is abandoned.
        nxt_rs       = byte_data;
        nxt_rs_valid = 1'b1;
        nxt_state    = is_one_byte(byte_data) ? DATA2 : DATA1;
      end else begin
        case (state)
          IDLE: begin
            if (rs_valid) begin
              if (is_one_byte(rs)) begin
                msg_done = 1'b1;
                msg_d1   = byte_data[6:0];
              end else begin
                nxt_d1    = byte_data[6:0];
                nxt_state = DATA2;
              end
            end
          end
          DATA1: begin
            nxt_d1    = byte_data[6:0];
            nxt_state = DATA2;
          end
          DATA2: begin
            msg_done  = 1'b1;
            if (is_one_byte(rs)) msg_d1 = byte_data[6:0];
            nxt_state = IDLE;
          end
          default: begin
            // SYSEX payload is discarded.
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rs       <= 8'h00;
      rs_valid <= 1'b0;
      d1       <= 7'h00;
    end else begin
      state    <= nxt_state;
      rs       <= nxt_rs;
      rs_valid <= nxt_rs_valid;
      d1       <= nxt_d1;
    end
  end

  // -------------------------------------------------------------------------
  // Voice state, updated the cycle after the completing byte
  // -------------------------------------------------------------------------
  logic ch_match;
  logic apply;

  assign ch_match = (OMNI != 0) || (rs[3:0] == CH);
  assign apply    = msg_done && ch_match;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      note_on     <= 1'b0;
      note_repeat <= 1'b0;
      note        <= 7'h00;
      vel         <= 7'h00;
      pb          <= PB_CENTRE;
      cc1         <= 2'd0;
    end else begin
      note_repeat <= 1'b0;
      if (apply) begin
        case (rs[7:4])
          4'h9, 4'h8: begin
            if (rs[7:4] == 4'h9 && msg_d2 != 7'd0) begin
              if (note_on && msg_d1 == note) note_repeat <= 1'b1;
              note    <= msg_d1;
              vel     <= msg_d2;
              note_on <= 1'b1;
            end else if (msg_d1 == note) begin
              // Release only the sounding note; a stale note-off for an
              // earlier note must not cut the current one.
              note_on <= 1'b0;
              vel     <= 7'd0;
            end
          end
          4'hE: pb <= {msg_d2, msg_d1[6:5]};
          4'hB: begin
            if (msg_d1 == 7'd1) cc1 <= msg_d2[6:5];
`ifdef MIDI_DEC_ALL_NOTES_OFF_EN
            if (msg_d1 == 7'd120 || msg_d1 == 7'd123) begin
              note_on <= 1'b0;
              vel     <= 7'd0;
            end
            if (msg_d1 == 7'd121) begin
              pb  <= PB_CENTRE;
              cc1 <= 2'd0;
            end
`else
            // CC120/121/123 are treated like any other controller.
`endif
          end
          default: begin
            // An, Cn, Dn: consumed without effect.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_voice_decoder.sv
// ---------------------------------------------------------------------------
// tb_midi_voice_decoder
//
// Directed bench for midi_voice_decoder (CHANNEL=0, OMNI=0). Bytes are driven
// on the falling edge and outputs sampled on a later falling edge, away from
// the rising edge the DUT captures on.
// ---------------------------------------------------------------------------
module tb_midi_voice_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       note_on;
  logic       note_repeat;
  logic [6:0] note;
  logic [6:0] vel;
  logic [8:0] pb;
  logic [1:0] cc1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  midi_voice_decoder #(.CHANNEL(0), .OMNI(0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .note_on     (note_on),
    .note_repeat (note_repeat),
    .note        (note),
    .vel         (vel),
    .pb          (pb),
    .cc1         (cc1)
  );

  // Present one byte for one cycle; consecutive calls give back-to-back bytes.
  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
  endtask

  // Drop the strobe; on return the last driven byte has been captured.
  task automatic idle();
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (note_on !== 1'b0)    begin failures++; $display("FAIL reset_note_on got=%0h exp=0", note_on); end
    checks++; if (note_repeat !== 1'b0) begin failures++; $display("FAIL reset_note_repeat got=%0h exp=0", note_repeat); end
    checks++; if (note !== 7'h00)      begin failures++; $display("FAIL reset_note got=%0h exp=0", note); end
    checks++; if (vel !== 7'h00)       begin failures++; $display("FAIL reset_vel got=%0h exp=0", vel); end
    checks++; if (pb !== 9'h100)       begin failures++; $display("FAIL reset_pb got=%0h exp=100", pb); end
    checks++; if (cc1 !== 2'd0)        begin failures++; $display("FAIL reset_cc1 got=%0h exp=0", cc1); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_note_on();
    drive(8'h90); drive(8'h3C); drive(8'h64); idle();
    checks++; if (note_on !== 1'b1)     begin failures++; $display("FAIL non_gate got=%0h exp=1", note_on); end
    checks++; if (note !== 7'h3C)       begin failures++; $display("FAIL non_note got=%0h exp=3c", note); end
    checks++; if (vel !== 7'h64)        begin failures++; $display("FAIL non_vel got=%0h exp=64", vel); end
    checks++; if (note_repeat !== 1'b0) begin failures++; $display("FAIL non_repeat got=%0h exp=0", note_repeat); end
  endtask

  task automatic test_repeat_and_off();
    drive(8'h90); drive(8'h3C); drive(8'h50); idle();
    checks++; if (note_repeat !== 1'b1) begin failures++; $display("FAIL rep_pulse got=%0h exp=1", note_repeat); end
    checks++; if (vel !== 7'h50)        begin failures++; $display("FAIL rep_vel got=%0h exp=50", vel); end
    idle();
    checks++; if (note_repeat !== 1'b0) begin failures++; $display("FAIL rep_pulse_width got=%0h exp=0", note_repeat); end
    checks++; if (note_on !== 1'b1)     begin failures++; $display("FAIL rep_gate got=%0h exp=1", note_on); end
    drive(8'h80); drive(8'h3C); drive(8'h00); idle();
    checks++; if (note_on !== 1'b0)     begin failures++; $display("FAIL off_gate got=%0h exp=0", note_on); end
    checks++; if (vel !== 7'h00)        begin failures++; $display("FAIL off_vel got=%0h exp=0", vel); end
    checks++; if (note !== 7'h3C)       begin failures++; $display("FAIL off_note got=%0h exp=3c", note); end
  endtask

  // Back-to-back bytes under running status.
  task automatic test_running_status();
    drive(8'h90); drive(8'h40); drive(8'h7F); drive(8'h43); drive(8'h7F); idle();
    checks++; if (note_on !== 1'b1)     begin failures++; $display("FAIL rs_gate got=%0h exp=1", note_on); end
    checks++; if (note !== 7'h43)       begin failures++; $display("FAIL rs_note got=%0h exp=43", note); end
    checks++; if (vel !== 7'h7F)        begin failures++; $display("FAIL rs_vel got=%0h exp=7f", vel); end
    checks++; if (note_repeat !== 1'b0) begin failures++; $display("FAIL rs_repeat got=%0h exp=0", note_repeat); end
    drive(8'h43); drive(8'h00); idle();
    checks++; if (note_on !== 1'b0)     begin failures++; $display("FAIL rs_off_gate got=%0h exp=0", note_on); end
    checks++; if (note !== 7'h43)       begin failures++; $display("FAIL rs_off_note got=%0h exp=43", note); end
  endtask

  task automatic test_pb_and_channel();
    drive(8'hE0); drive(8'h00); drive(8'h60); idle();
    checks++; if (pb !== 9'h180)        begin failures++; $display("FAIL pb_value got=%0h exp=180", pb); end
    drive(8'h91); drive(8'h3C); drive(8'h64); drive(8'h45); drive(8'h10); idle();
    checks++; if (note_on !== 1'b0)     begin failures++; $display("FAIL ch_gate got=%0h exp=0", note_on); end
    checks++; if (note !== 7'h43)       begin failures++; $display("FAIL ch_note got=%0h exp=43", note); end
    checks++; if (vel !== 7'h00)        begin failures++; $display("FAIL ch_vel got=%0h exp=0", vel); end
  endtask

  task automatic test_realtime_sysex();
    drive(8'h90); drive(8'h3C); drive(8'hF8); drive(8'h64); idle();
    checks++; if (note_on !== 1'b1)     begin failures++; $display("FAIL rt_gate got=%0h exp=1", note_on); end
    checks++; if (vel !== 7'h64)        begin failures++; $display("FAIL rt_vel got=%0h exp=64", vel); end
    checks++; if (note !== 7'h3C)       begin failures++; $display("FAIL rt_note got=%0h exp=3c", note); end
    // After SysEx running status is gone, so 3C 00 must not release the note.
    drive(8'hF0); drive(8'h11); drive(8'h22); drive(8'hF7); drive(8'h3C); drive(8'h00); idle();
    checks++; if (note_on !== 1'b1)     begin failures++; $display("FAIL sx_gate got=%0h exp=1", note_on); end
    checks++; if (vel !== 7'h64)        begin failures++; $display("FAIL sx_vel got=%0h exp=64", vel); end
    // SysEx terminated by a channel status byte.
    drive(8'hF0); drive(8'h05); drive(8'hE0); drive(8'h20); drive(8'h50); idle();
    checks++; if (pb !== 9'h141)        begin failures++; $display("FAIL sx_pb got=%0h exp=141", pb); end
  endtask

  task automatic test_cc_and_abandon();
    // Partial note-on abandoned by a CC1 message.
    drive(8'h90); drive(8'h30); drive(8'hB0); drive(8'h01); drive(8'h40); idle();
    checks++; if (cc1 !== 2'd2)         begin failures++; $display("FAIL ab_cc1 got=%0h exp=2", cc1); end
    checks++; if (note !== 7'h3C)       begin failures++; $display("FAIL ab_note got=%0h exp=3c", note); end
    drive(8'hB0); drive(8'h01); drive(8'h7F); idle();
    checks++; if (cc1 !== 2'd3)         begin failures++; $display("FAIL cc1_max got=%0h exp=3", cc1); end
    // Program change under running status: single data bytes, no effect.
    drive(8'hC0); drive(8'h05); drive(8'h3C); drive(8'h00); idle();
    checks++; if (note_on !== 1'b1)     begin failures++; $display("FAIL pc_gate got=%0h exp=1", note_on); end
    drive(8'hB0); drive(8'h7B); drive(8'h00); idle();
`ifdef MIDI_DEC_ALL_NOTES_OFF_EN
    checks++; if (note_on !== 1'b0)     begin failures++; $display("FAIL cc123_gate got=%0h exp=0", note_on); end
    checks++; if (vel !== 7'h00)        begin failures++; $display("FAIL cc123_vel got=%0h exp=0", vel); end
`else
    checks++; if (note_on !== 1'b1)     begin failures++; $display("FAIL cc123_gate got=%0h exp=1", note_on); end
    checks++; if (vel !== 7'h64)        begin failures++; $display("FAIL cc123_vel got=%0h exp=64", vel); end
`endif
    checks++; if (note !== 7'h3C)       begin failures++; $display("FAIL cc123_note got=%0h exp=3c", note); end
  endtask

  task automatic test_async_reset();
    drive(8'h90); drive(8'h55);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (note !== 7'h00)       begin failures++; $display("FAIL arst_note got=%0h exp=0", note); end
    checks++; if (vel !== 7'h00)        begin failures++; $display("FAIL arst_vel got=%0h exp=0", vel); end
    checks++; if (note_on !== 1'b0)     begin failures++; $display("FAIL arst_gate got=%0h exp=0", note_on); end
    checks++; if (pb !== 9'h100)        begin failures++; $display("FAIL arst_pb got=%0h exp=100", pb); end
    checks++; if (cc1 !== 2'd0)         begin failures++; $display("FAIL arst_cc1 got=%0h exp=0", cc1); end
    idle();
    reset_n = 1'b1;
    // Running status and the partial message are gone: 7F must be ignored.
    drive(8'h7F); idle();
    checks++; if (note_on !== 1'b0)     begin failures++; $display("FAIL arst_rs_gate got=%0h exp=0", note_on); end
    checks++; if (note !== 7'h00)       begin failures++; $display("FAIL arst_rs_note got=%0h exp=0", note); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_repeat_and_off();
    test_running_status();
    test_pb_and_channel();
    test_realtime_sysex();
    test_cc_and_abandon();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
